sorter_param: RTL and testbench

- Parametrised successor to the board-level 4x4-bit sorter. Sorts N unsigned W-bit elements in place with an odd-even transposition network.
- Compares all disjoint adjacent pairs in parallel each cycle. Terminates early once the data is sorted.
- Runtime-selectable ascending or descending order, start/busy/done handshake.
- Sits between the switch/input capture logic and the display/LED drivers on the lab board.

---
 rtl/sorter_pkg.sv | 22 ++
 rtl/sorter_cas.sv | 20 ++
 rtl/sorter_param.sv | 130 +++++++++++++
 tb/tb_sorter_param.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/sorter_pkg.sv
// Shared types and the compare-and-swap decision for the odd-even transposition sorter.
// Pure definitions; no timing or flow control of its own.
package sorter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SORT = 1'b1
  } state_t;

  localparam logic EVEN = 1'b0;
  localparam logic ODD  = 1'b1;

  // Widest element the shared decision function handles; cells zero-extend into it.
  localparam int CMP_MAXW = 64;

  function automatic logic cmp_swap(input logic [CMP_MAXW-1:0] a,
                                    input logic [CMP_MAXW-1:0] b,
                                    input logic                desc);
    return desc ? (a < b) : (a > b);
  endfunction

endpackage

// File: rtl/sorter_cas.sv
// One compare-and-swap cell: lo goes to the lower index, hi to the upper index.
// Purely combinational, zero latency, no flow control.
module sorter_cas
  import sorter_pkg::*;
#(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         desc,
  output logic [W-1:0] lo,
  output logic [W-1:0] hi,
  output logic         swapped
);

  assign swapped = cmp_swap(CMP_MAXW'(a), CMP_MAXW'(b), desc);
  assign lo      = swapped ? b : a;
  assign hi      = swapped ? a : b;

endmodule

// File: rtl/sorter_param.sv
// In-place odd-even transposition sorter, one phase per clock (per step pulse with SORT_STEP_EN);
// done after 2..N phase edges from the load edge, start is ignored while busy.
module sorter_param
  import sorter_pkg::*;
#(
  parameter int N  = 4,
  parameter int W  = 4,
  parameter int CW = $clog2(N+1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          desc,
  input  logic [N*W-1:0] din,
  output logic [N*W-1:0] dout,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] phases
`ifdef SORT_STEP_EN
  ,
  input  logic          step
`endif
);

  localparam int NE = N / 2;
  localparam int NO = (N - 1) / 2;

  state_t         state;
  logic           parity;
  logic           swap_prev;
  logic           desc_q;
  logic [N*W-1:0] even_nxt, odd_nxt, nxt;
  logic [N-1:0]   even_sw, odd_sw;
  logic           any_swap, phase_en, last;

  for (genvar p = 0; p < N; p++) begin : g_even
    if (p < NE) begin : g_cell
      sorter_cas #(.W(W)) u_cas (
        .a       (dout[2*p*W +: W]),
        .b       (dout[(2*p+1)*W +: W]),
        .desc    (desc_q),
        .lo      (even_nxt[2*p*W +: W]),
        .hi      (even_nxt[(2*p+1)*W +: W]),
        .swapped (even_sw[p])
      );
    end else begin : g_none
      assign even_sw[p] = 1'b0;
    end
  end

  if (N % 2 == 1) begin : g_even_tail
    assign even_nxt[(N-1)*W +: W] = dout[(N-1)*W +: W];
  end

  for (genvar p = 0; p < N; p++) begin : g_odd
    if (p < NO) begin : g_cell
      sorter_cas #(.W(W)) u_cas (
        .a       (dout[(2*p+1)*W +: W]),
        .b       (dout[(2*p+2)*W +: W]),
        .desc    (desc_q),
        .lo      (odd_nxt[(2*p+1)*W +: W]),
        .hi      (odd_nxt[(2*p+2)*W +: W]),
        .swapped (odd_sw[p])
      );
    end else begin : g_none
      assign odd_sw[p] = 1'b0;
    end
  end

  // Element 0 never pairs in an odd phase; the top element only when N is even.
  assign odd_nxt[W-1:0] = dout[W-1:0];
  if (N % 2 == 0) begin : g_odd_tail
    assign odd_nxt[(N-1)*W +: W] = dout[(N-1)*W +: W];
  end

  assign nxt      = (parity == EVEN) ? even_nxt : odd_nxt;
  assign any_swap = (parity == EVEN) ? |even_sw : |odd_sw;

  // Two consecutive swap-free phases prove the data sorted; N phases always suffice.
  assign last = (phases == CW'(N-1)) || (!any_swap && !swap_prev);

`ifdef SORT_STEP_EN
  assign phase_en = step;
`else
  assign phase_en = 1'b1;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      dout      <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      phases    <= '0;
      desc_q    <= 1'b0;
      parity    <= EVEN;
      swap_prev <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            dout      <= din;
            desc_q    <= desc;
            phases    <= '0;
            parity    <= EVEN;
            swap_prev <= 1'b1;
            done      <= 1'b0;
            busy      <= 1'b1;
            state     <= SORT;
          end
        end
        SORT: begin
          if (phase_en) begin
            dout      <= nxt;
            phases    <= phases + CW'(1);
            parity    <= ~parity;
            swap_prev <= any_swap;
            if (last) begin
              state <= IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sorter_param.sv
// Bench for sorter_param: N=4/W=4 directed vectors and N=7/W=8 random vectors against a phase-level model.
module tb_sorter_param;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        st4, ds4, busy4, done4;
  logic [15:0] din4, dout4;
  logic [2:0]  ph4;
  logic        st7, ds7, busy7, done7;
  logic [55:0] din7, dout7;
  logic [2:0]  ph7;
`ifdef SORT_STEP_EN
  logic        step;
`endif

  int checks = 0;
  int errors = 0;

  int exp_tr [2][8][7];
  int exp_nph[2];
  bit armed  [2];
  int kk     [2];

  sorter_param #(.N(4), .W(4)) u4 (
    .clk(clk), .rst(rst), .start(st4), .desc(ds4), .din(din4), .dout(dout4),
    .busy(busy4), .done(done4), .phases(ph4)
`ifdef SORT_STEP_EN
    , .step(step)
`endif
  );

  sorter_param #(.N(7), .W(8)) u7 (
    .clk(clk), .rst(rst), .start(st7), .desc(ds7), .din(din7), .dout(dout7),
    .busy(busy7), .done(done7), .phases(ph7)
`ifdef SORT_STEP_EN
    , .step(step)
`endif
  );

  function automatic int nn(int d); return (d == 0) ? 4 : 7; endfunction
  function automatic int ww(int d); return (d == 0) ? 4 : 8; endfunction

  function automatic logic [55:0] pack(int d, int v[7]);
    logic [55:0] r = '0;
    for (int i = 0; i < nn(d); i++) r |= 56'(v[i]) << (i * ww(d));
    return r;
  endfunction

  function automatic logic [55:0] dout_of(int d); return (d == 0) ? 56'(dout4) : dout7; endfunction
  function automatic logic busy_of(int d); return (d == 0) ? busy4 : busy7; endfunction
  function automatic logic done_of(int d); return (d == 0) ? done4 : done7; endfunction
  function automatic logic [2:0] ph_of(int d); return (d == 0) ? ph4 : ph7; endfunction

  task automatic chk(string nm, longint act, longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Array-level transposition sort: snapshot after every phase, stop on the early-exit rule.
  task automatic model(int d, int v[7], bit dsc);
    int a[7];
    bit sw, swp;
    int t;
    int n = nn(d);
    a = v;
    exp_tr[d][0] = a;
    swp = 1'b1;
    exp_nph[d] = 0;
    for (int p = 0; p < n; p++) begin
      sw = 1'b0;
      for (int i = p % 2; i + 1 < n; i += 2)
        if (dsc ? (a[i] < a[i+1]) : (a[i] > a[i+1])) begin
          t = a[i]; a[i] = a[i+1]; a[i+1] = t; sw = 1'b1;
        end
      exp_tr[d][p+1] = a;
      exp_nph[d] = p + 1;
      if (!sw && !swp) break;
      swp = sw;
    end
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (armed[d]) begin
        int k;
        k = kk[d];
        chk($sformatf("trace_d%0d_k%0d_dout", d, k), dout_of(d), pack(d, exp_tr[d][k]));
        chk($sformatf("trace_d%0d_k%0d_busy", d, k), busy_of(d), (k < exp_nph[d]) ? 1 : 0);
        chk($sformatf("trace_d%0d_k%0d_done", d, k), done_of(d), (k == exp_nph[d]) ? 1 : 0);
        chk($sformatf("trace_d%0d_k%0d_phases", d, k), ph_of(d), k);
        if (k == exp_nph[d]) armed[d] = 1'b0;
        else kk[d] = k + 1;
      end
    end
  end

  task automatic launch(int d, int v[7], bit dsc, bit hold, bit use_lit, int lit_nph, logic [55:0] lit_out);
    logic [55:0] pk, srt;
    int q[$];
    int n = nn(d);
    model(d, v, dsc);
    @(negedge clk); #1;
    pk = pack(d, v);
    if (d == 0) begin din4 = pk[15:0]; ds4 = dsc; st4 = 1'b1; end
    else        begin din7 = pk;       ds7 = dsc; st7 = 1'b1; end
    @(posedge clk); #1;
    if (!hold) begin st4 = 1'b0; st7 = 1'b0; end
    // Inputs moving after the load edge must not disturb the sort.
    if (d == 0) begin ds4 = ~dsc; din4 = ~din4; end
    else        begin ds7 = ~dsc; din7 = ~din7; end
    kk[d] = 0;
    armed[d] = 1'b1;
    for (int c = 0; c < 40 && armed[d]; c++) begin
      @(negedge clk); #1;
    end
    chk($sformatf("finish_in_budget_d%0d", d), armed[d], 0);
    armed[d] = 1'b0;
    st4 = 1'b0; st7 = 1'b0;
    for (int i = 0; i < n; i++) q.push_back(v[i]);
    if (dsc) q.rsort(); else q.sort();
    srt = '0;
    for (int i = 0; i < n; i++) srt |= 56'(q[i]) << (i * ww(d));
    @(negedge clk);
    chk($sformatf("sorted_d%0d", d), dout_of(d), srt);
    chk($sformatf("done_hold_d%0d", d), done_of(d), 1);
    chk($sformatf("busy_idle_d%0d", d), busy_of(d), 0);
    if (use_lit) begin
      chk("lit_out", dout_of(d), lit_out);
      chk("lit_phases", ph_of(d), lit_nph);
      chk("model_nph", exp_nph[d], lit_nph);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [55:0] pk;
    int v[7];
    st4 = 1'b0; ds4 = 1'b0; din4 = '0;
    st7 = 1'b0; ds7 = 1'b0; din7 = '0;
    armed[0] = 1'b0; armed[1] = 1'b0;
`ifdef SORT_STEP_EN
    step = 1'b1;
`endif
    repeat (2) @(negedge clk);
    chk("rst_dout4", dout4, 0);
    chk("rst_busy4", busy4, 0);
    chk("rst_done4", done4, 0);
    chk("rst_ph4", ph4, 0);
    chk("rst_dout7", dout7, 0);
    chk("rst_done7", done7, 0);
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_busy4", busy4, 0);
    chk("idle_done4", done4, 0);

    launch(0, '{3,9,1,7,0,0,0}, 1'b1, 1'b0, 1'b1, 4, 56'h1379);
    launch(0, '{3,9,1,7,0,0,0}, 1'b0, 1'b0, 1'b1, 4, 56'h9731);
    launch(0, '{9,7,3,1,0,0,0}, 1'b0, 1'b0, 1'b1, 4, 56'h9731);
    launch(0, '{1,3,7,9,0,0,0}, 1'b0, 1'b0, 1'b1, 2, 56'h9731);
    launch(0, '{5,5,2,5,0,0,0}, 1'b1, 1'b1, 1'b1, 3, 56'h2555);
    repeat (3) @(negedge clk);
    chk("done_sticky", done4, 1);
    chk("dout_sticky", dout4, 16'h2555);

    // Reset landing on the first phase edge.
    @(negedge clk); #1;
    v = '{3,9,1,7,0,0,0};
    pk = pack(0, v);
    din4 = pk[15:0]; ds4 = 1'b1; st4 = 1'b1;
    @(posedge clk); #1 st4 = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    chk("abort_dout", dout4, 0);
    chk("abort_busy", busy4, 0);
    chk("abort_done", done4, 0);
    chk("abort_ph", ph4, 0);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_stay_idle", busy4, 0);
    launch(0, '{3,9,1,7,0,0,0}, 1'b0, 1'b0, 1'b1, 4, 56'h9731);

    launch(1, '{7,6,5,4,3,2,1}, 1'b0, 1'b0, 1'b1, 7, 56'h07060504030201);
    for (int j = 0; j < 1000; j++) begin
      for (int i = 0; i < 7; i++)
        v[i] = (j % 4 == 0) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 255));
      launch(1, v, j[0], 1'b0, 1'b0, 0, '0);
    end

`ifdef SORT_STEP_EN
    v = '{3,9,1,7,0,0,0};
    model(0, v, 1'b1);
    step = 1'b0;
    @(negedge clk); #1;
    pk = pack(0, v);
    din4 = pk[15:0]; ds4 = 1'b1; st4 = 1'b1;
    @(posedge clk); #1 st4 = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("step_hold_dout", dout4, pack(0, exp_tr[0][0]));
      chk("step_hold_ph", ph4, 0);
    end
    #1 step = 1'b1;
    @(posedge clk); #1 step = 1'b0;
    @(negedge clk);
    chk("step_one_ph", ph4, 1);
    chk("step_one_dout", dout4, pack(0, exp_tr[0][1]));
    #1 step = 1'b1;
    for (int c = 0; c < 20 && !done4; c++) @(negedge clk);
    chk("step_done", done4, 1);
    chk("step_result", dout4, 16'h1379);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
